wb_arb5: RTL and testbench
==========================

Name: wb_arb5

Overview:
- Five-master Wishbone bus arbiter that produces the one-hot grant vector consumed by the shared 32-bit master-output data mux.
- Routes slave ack/err back to the granted master only.
- Rotates priority round-robin.
- Watchdog timer terminates hung cycles with an error to the owning master.
- Sits between the DMA/host masters and the single shared slave port.

Parameters:
- TO_W, 8, width of watchdog counter.
- TIMEOUT, 255, cycles without ack/err before forced error; legal range 2..2^TO_W-1.

Ports:
- wb_clk_i  input  1  bus clock; all state updates on posedge.
- wb_rst_i  input  1  synchronous reset, active-low (reset when 0 at posedge).
- req_i     input  5  per-master cycle request (master cyc); bit i = master i.
- s_ack_i   input  1  slave acknowledge.
- s_err_i   input  1  slave error.
- gnt_o     output 5  one-hot or zero grant, registered; drives mux select.
- s_cyc_o   output 1  cycle to slave = |gnt_o.
- ack_o     output 5  per-master ack.
- err_o     output 5  per-master err.
- busy_o    output 1  state == BUSY.

Behaviour:
Reset:
- gnt_o = 0, last = 4 (master 0 wins first), state IDLE.
- cnt = 0, to_err = 0; all outputs 0.
- Reset mid-cycle drops the grant on the next edge; no error is generated.

State machine:
- IDLE:
  - If req_i != 0, pick the first set bit searching last+1, last+2, ... wrapping mod 5.
  - Next edge: gnt_o = one-hot(winner), last = winner, state BUSY.
  - Latency req->gnt = 1 cycle.
- BUSY:
  - gnt_o is held constant.
  - If req_i[winner] == 0 at an edge: gnt_o = 0, state IDLE.
  - Minimum 1 idle cycle between grants; no back-to-back handover.
  - Other masters' requests are ignored while BUSY.

Routing (combinational):
- ack_o = gnt_o & {5{s_ack_i}}.
- err_o = gnt_o & {5{s_err_i | to_err}}.
- Ungranted masters always see 0.

Watchdog:
- In BUSY, cnt increments each cycle with s_ack_i == 0 and s_err_i == 0.
- cnt clears on ack, on err, and on leaving BUSY.
- When cnt == TIMEOUT-1 and no ack/err: next edge to_err = 1 and cnt = 0.
- to_err is a single-cycle pulse; no wrap past TIMEOUT.
- Arbiter stays BUSY until the master drops its request.

Boundary conditions:
- Ack and request-drop in the same cycle: ack still delivered that cycle; release on that edge.
- Request drops in the cycle the grant is issued: grant is held one cycle, then released; no ack is fabricated.
- s_ack_i and s_err_i together: both routed unchanged.
- Ack on the same edge the timeout fires: counter clears; no to_err.
- s_ack_i in IDLE: ignored (gnt_o = 0).
- Only requester is `last`: it wins again (search wraps to itself).

Decomposition:
- Shared package wb_arb_pkg holds:
  - NMASTER = 5.
  - State encoding IDLE = 1'b0, BUSY = 1'b1.
  - Grant vector typedef of width NMASTER.
- One combinational sub-module rr_pick5:
  - Inputs: req[4:0], last[2:0].
  - Outputs: valid, idx[2:0].
  - Implementation: rotate, fixed-priority encode, un-rotate mod 5.

Test Plan:
- Reset priority: after reset, req_i = 5'b10001 -> gnt_o = 5'b00001 one cycle later.
  - Hold req[0] 3 cycles, then drop -> gnt_o = 0 on the next edge.
  - req_i still 5'b10000 -> gnt_o = 5'b10000 after 1 idle cycle.
- Round-robin fairness: req_i = 5'b11111 continuously, each master dropping after one acked transfer -> grant order 0,1,2,3,4,0 with exactly one idle cycle between grants.
- Routing isolation: gnt_o = 5'b00100, pulse s_ack_i -> ack_o = 5'b00100 the same cycle, all other bits 0.
  - s_err_i pulse -> err_o = 5'b00100.
- Watchdog: TIMEOUT = 4, grant master 1, no ack -> err_o = 5'b00010 for exactly 1 cycle, 4 cycles after the first BUSY cycle.
  - Ack at cycle 3 instead -> no error.
- Mid-operation reset: wb_rst_i = 0 for 1 cycle while gnt_o = 5'b01000 -> gnt_o = 0, busy_o = 0 next edge.
  - Subsequent req_i = 5'b01001 -> master 0 granted.
- Edge wrap: last = 4, req_i = 5'b10000 only -> master 4 re-granted.
  - Same-cycle ack and request-drop -> ack_o[4] = 1 that cycle, gnt_o = 0 next.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the five-master Wishbone arbiter.
package wb_arb_pkg;

  localparam int unsigned NMASTER = 5;

  typedef logic [NMASTER-1:0] gnt_t;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

  function automatic logic [2:0] wrap5(input int unsigned v);
    return 3'(v % NMASTER);
  endfunction

endpackage

// File: rtl/wb_arb5_if.sv
// Request/grant/response bundle between the bus masters and the arbiter.
interface wb_arb5_if;
  import wb_arb_pkg::*;

  gnt_t req_i;
  logic s_ack_i;
  logic s_err_i;
  gnt_t gnt_o;
  logic s_cyc_o;
  gnt_t ack_o;
  gnt_t err_o;
  logic busy_o;

  modport master (
    output req_i, s_ack_i, s_err_i,
    input  gnt_o, s_cyc_o, ack_o, err_o, busy_o
  );

  modport slave (
    input  req_i, s_ack_i, s_err_i,
    output gnt_o, s_cyc_o, ack_o, err_o, busy_o
  );

endinterface

// File: rtl/rr_pick5.sv
// Round-robin pick: first requester strictly after last_i, wrapping mod 5.
module rr_pick5
  import wb_arb_pkg::*;
(
  input  gnt_t       req_i,
  input  logic [2:0] last_i,
  output logic       valid_o,
  output logic [2:0] idx_o
);

  gnt_t       w_rot;
  logic [2:0] w_ofs;

  always_comb begin
    w_rot = '0;
    for (int unsigned j = 0; j < NMASTER; j++) begin
      w_rot[j] = req_i[wrap5(32'(last_i) + 32'd1 + j)];
    end
    w_ofs = '0;
    // Scan downwards so the lowest rotated position wins.
    for (int j = int'(NMASTER) - 1; j >= 0; j--) begin
      if (w_rot[j]) w_ofs = 3'(j);
    end
    valid_o = |req_i;
    idx_o   = wrap5(32'(last_i) + 32'(w_ofs) + 32'd1);
  end

endmodule

// File: rtl/wb_arb5.sv
// Five-master round-robin Wishbone arbiter with a hung-cycle watchdog.
module wb_arb5
  import wb_arb_pkg::*;
#(
  parameter int unsigned TO_W    = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input logic        wb_clk_i,
  input logic        wb_rst_i,
  wb_arb5_if.slave   bus
);

  state_e          r_state;
  gnt_t            r_gnt;
  logic [2:0]      r_last;
  logic [TO_W-1:0] r_cnt;
  logic            r_to_err;

  logic       w_valid;
  logic [2:0] w_idx;
  logic       w_hold;
  logic       w_term;
  logic       w_expire;

  rr_pick5 u_pick (
    .req_i   (bus.req_i),
    .last_i  (r_last),
    .valid_o (w_valid),
    .idx_o   (w_idx)
  );

  assign w_hold   = |(bus.req_i & r_gnt);
  assign w_term   = bus.s_ack_i | bus.s_err_i;
  assign w_expire = (r_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      r_state  <= StIdle;
      r_gnt    <= '0;
      r_last   <= 3'd4;
      r_cnt    <= '0;
      r_to_err <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_cnt    <= '0;
          r_to_err <= 1'b0;
          if (w_valid) begin
            r_gnt   <= gnt_t'(1) << w_idx;
            r_last  <= w_idx;
            r_state <= StBusy;
          end
        end
        StBusy: begin
          if (!w_hold) begin
            r_gnt    <= '0;
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_to_err <= 1'b0;
          end else if (w_term) begin
            // A real response on the expiry edge wins over the watchdog.
            r_cnt    <= '0;
            r_to_err <= 1'b0;
          end else if (w_expire) begin
            r_cnt    <= '0;
            r_to_err <= 1'b1;
          end else begin
            r_cnt    <= r_cnt + 1'b1;
            r_to_err <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.gnt_o   = r_gnt;
  assign bus.s_cyc_o = |r_gnt;
  assign bus.ack_o   = r_gnt & {NMASTER{bus.s_ack_i}};
  assign bus.err_o   = r_gnt & {NMASTER{bus.s_err_i | r_to_err}};
  assign bus.busy_o  = (r_state == StBusy);

endmodule

// File: tb/tb_wb_arb5.sv
// Directed vector table, round-robin sequence and random traffic vs. a reference model.
module tb_wb_arb5;

  localparam int TIMEOUT = 4;

  typedef struct {
    logic       rn;
    logic [4:0] req;
    logic       a;
    logic       e;
    logic [4:0] gnt;
    logic [4:0] ack;
    logic [4:0] err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: owning master (-1 = none), last winner, quiet-cycle count.
  int m_owner = -1;
  int m_last  = 4;
  int m_quiet = 0;
  bit m_pend  = 1'b0;
  bit m_valid = 1'b0;

  wb_arb5_if bus ();

  wb_arb5 #(
    .TO_W    (8),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] pack(input logic [4:0] g, input logic [4:0] ak,
                                       input logic [4:0] er);
    return {g, |g, ak, er, |g};
  endfunction

  function automatic logic [16:0] model_exp(input logic a, input logic e);
    logic [4:0] g;
    g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return pack(g, g & {5{a}}, g & {5{e | m_pend}});
  endfunction

  function automatic void model_step(input logic rn, input logic [4:0] rq, input logic a,
                                     input logic e);
    int idx;
    if (!rn) begin
      m_owner = -1; m_last = 4; m_quiet = 0; m_pend = 1'b0;
    end else if (m_owner < 0) begin
      m_quiet = 0; m_pend = 1'b0;
      for (int k = 1; k <= 5; k++) begin
        idx = (m_last + k) % 5;
        if (rq[idx] && m_owner < 0) m_owner = idx;
      end
      if (m_owner >= 0) m_last = m_owner;
    end else if (!rq[m_owner]) begin
      m_owner = -1; m_quiet = 0; m_pend = 1'b0;
    end else if (a || e) begin
      m_quiet = 0; m_pend = 1'b0;
    end else begin
      m_quiet++;
      m_pend = (m_quiet == TIMEOUT);
      if (m_pend) m_quiet = 0;
    end
  endfunction

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic rn, input logic [4:0] rq, input logic a, input logic e,
                       output logic [16:0] o);
    rst_n = rn; bus.req_i = rq; bus.s_ack_i = a; bus.s_err_i = e;
    @(negedge clk);
    o = {bus.gnt_o, bus.s_cyc_o, bus.ack_o, bus.err_o, bus.busy_o};
    if (m_valid) check("model", o, model_exp(a, e));
    @(posedge clk);
    model_step(rn, rq, a, e);
    m_valid = 1'b1;
    #1;
  endtask

  function automatic vec_t v(input logic rn, input logic [4:0] rq, input logic a,
                             input logic e, input logic [4:0] g, input logic [4:0] ak,
                             input logic [4:0] er);
    vec_t r;
    r.rn = rn; r.req = rq; r.a = a; r.e = e; r.gnt = g; r.ack = ak; r.err = er;
    return r;
  endfunction

  initial begin
    vec_t       tbl[$];
    logic [16:0] o;
    logic [4:0]  bitv;
    logic [4:0]  rq;
    logic        rn;

    // Reset priority, hold/drop, then master 4 after one idle cycle.
    tbl.push_back(v(1, 5'b10001, 0, 0, 5'b00000, 5'b00000, 5'b00000));
    for (int i = 0; i < 3; i++) tbl.push_back(v(1, 5'b10001, 0, 0, 5'b00001, 0, 0));
    tbl.push_back(v(1, 5'b10000, 0, 0, 5'b00001, 0, 0));
    tbl.push_back(v(1, 5'b10000, 0, 0, 5'b00000, 0, 0));
    tbl.push_back(v(1, 5'b10000, 0, 0, 5'b10000, 0, 0));
    // Ack with drop, wrap-around re-grant of master 4, ack ignored in idle.
    tbl.push_back(v(1, 5'b00000, 1, 0, 5'b10000, 5'b10000, 0));
    tbl.push_back(v(1, 5'b10000, 0, 0, 5'b00000, 0, 0));
    tbl.push_back(v(1, 5'b10000, 1, 0, 5'b10000, 5'b10000, 0));
    tbl.push_back(v(1, 5'b00000, 1, 0, 5'b10000, 5'b10000, 0));
    tbl.push_back(v(1, 5'b00000, 1, 0, 5'b00000, 0, 0));
    // Routing isolation on master 2.
    tbl.push_back(v(1, 5'b00100, 0, 0, 5'b00000, 0, 0));
    tbl.push_back(v(1, 5'b00100, 1, 0, 5'b00100, 5'b00100, 0));
    tbl.push_back(v(1, 5'b00100, 0, 1, 5'b00100, 0, 5'b00100));
    tbl.push_back(v(1, 5'b00100, 1, 1, 5'b00100, 5'b00100, 5'b00100));
    tbl.push_back(v(1, 5'b00100, 0, 0, 5'b00100, 0, 0));
    tbl.push_back(v(1, 5'b00000, 0, 0, 5'b00100, 0, 0));
    tbl.push_back(v(1, 5'b00000, 0, 0, 5'b00000, 0, 0));
    // Watchdog fires on master 1 four cycles into BUSY.
    tbl.push_back(v(1, 5'b00010, 0, 0, 5'b00000, 0, 0));
    for (int i = 0; i < 4; i++) tbl.push_back(v(1, 5'b00010, 0, 0, 5'b00010, 0, 0));
    tbl.push_back(v(1, 5'b00010, 0, 0, 5'b00010, 0, 5'b00010));
    tbl.push_back(v(1, 5'b00010, 0, 0, 5'b00010, 0, 0));
    tbl.push_back(v(1, 5'b00000, 0, 0, 5'b00010, 0, 0));
    // Ack on the expiry cycle suppresses the watchdog.
    tbl.push_back(v(1, 5'b00010, 0, 0, 5'b00000, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(v(1, 5'b00010, 0, 0, 5'b00010, 0, 0));
    tbl.push_back(v(1, 5'b00010, 1, 0, 5'b00010, 5'b00010, 0));
    tbl.push_back(v(1, 5'b00010, 0, 0, 5'b00010, 0, 0));
    tbl.push_back(v(1, 5'b00000, 0, 0, 5'b00010, 0, 0));
    tbl.push_back(v(1, 5'b00000, 0, 0, 5'b00000, 0, 0));
    // Request dropped in the grant cycle: grant held once, no ack.
    tbl.push_back(v(1, 5'b00001, 0, 0, 5'b00000, 0, 0));
    tbl.push_back(v(1, 5'b00000, 0, 0, 5'b00001, 0, 0));
    tbl.push_back(v(1, 5'b00000, 0, 0, 5'b00000, 0, 0));
    // Mid-cycle reset on master 3, then master 0 wins.
    tbl.push_back(v(1, 5'b01000, 0, 0, 5'b00000, 0, 0));
    tbl.push_back(v(1, 5'b01000, 0, 0, 5'b01000, 0, 0));
    tbl.push_back(v(0, 5'b01000, 0, 0, 5'b01000, 0, 0));
    tbl.push_back(v(1, 5'b01001, 0, 0, 5'b00000, 0, 0));
    tbl.push_back(v(1, 5'b01001, 0, 0, 5'b00001, 0, 0));
    tbl.push_back(v(1, 5'b00000, 0, 0, 5'b00001, 0, 0));
    tbl.push_back(v(1, 5'b00000, 0, 0, 5'b00000, 0, 0));

    bus.req_i = '0; bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0;
    apply(1'b0, 5'b0, 1'b0, 1'b0, o);
    apply(1'b0, 5'b0, 1'b0, 1'b0, o);
    check("reset_state", o, 17'h0);

    foreach (tbl[i]) begin
      apply(tbl[i].rn, tbl[i].req, tbl[i].a, tbl[i].e, o);
      check($sformatf("vec%0d", i), o, pack(tbl[i].gnt, tbl[i].ack, tbl[i].err));
    end

    // Round-robin fairness with every master requesting.
    apply(1'b0, 5'b0, 1'b0, 1'b0, o);
    for (int k = 0; k < 6; k++) begin
      bitv = 5'(1 << (k % 5));
      apply(1'b1, 5'b11111, 1'b0, 1'b0, o);
      check($sformatf("rr_idle%0d", k), 17'(o[16:12]), 17'h0);
      apply(1'b1, 5'b11111 & ~bitv, 1'b1, 1'b0, o);
      check($sformatf("rr_gnt%0d", k), 17'(o[16:12]), 17'(bitv));
      check($sformatf("rr_ack%0d", k), 17'(o[10:6]), 17'(bitv));
    end

    // Random traffic with sticky requests.
    rq = '0;
    for (int c = 0; c < 3000; c++) begin
      rq = rq ^ 5'($urandom & $urandom);
      rn = ($urandom_range(99) != 0);
      apply(rn, rq, ($urandom_range(3) == 0), ($urandom_range(15) == 0), o);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
